matrix_mult: RTL and testbench

Streaming matrix-multiply engine computing OUT[M×O] = IN[M×N] · W[N×O]. It reads one input row and one weight row per cycle from external synchronous-read memories, forms an N-lane dot product, and collects O results per row. Each completed output row goes out as a single write to an external output memory.

---
 rtl/matrix_mult.sv | 193 +++++++++++++++++++
 tb/tb_matrix_mult.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_mult
//  Purpose  : Streaming matrix multiply OUT[MxO] = IN[MxN] * W[NxO].
//             Walks (m, o) through all M*O pairs, one address pair per cycle,
//             reads one IN row and one transposed W row from synchronous-read
//             memories, forms an N-lane signed dot product and gathers O
//             results per row. Each completed row is emitted as one write.
//  Ports    : clk, rst_n (async, active-low), start (level, sampled in IDLE)
//             inputData/weightData  - memory read data (1-cycle latency)
//             inputAddr/weightAddr  - memory read addresses (m, o)
//             outputData/outputAddr - completed OUT row and its row index
//             outputWrEn            - one-cycle write strobe
//  Config   : MATRIX_MULT_SATURATE_EN - clamp each dot product to the signed
//             OUTPUT_WIDTH range instead of keeping the low bits (wrap).
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_mult #(
  parameter int BATCH_SIZE          = 8,
  parameter int LOG_BATCH_SIZE      = 3,
  parameter int INPUT_FEATURES      = 4,
  parameter int LOG_INPUT_FEATURES  = 2,
  parameter int OUTPUT_FEATURES     = 8,
  parameter int LOG_OUTPUT_FEATURES = 3,
  parameter int INPUT_WIDTH         = 4,
  parameter int WEIGHT_WIDTH        = 8,
  parameter int OUTPUT_WIDTH        = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]     inputData,
  input  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0]    weightData,
  output logic [LOG_BATCH_SIZE-1:0]                 inputAddr,
  output logic [LOG_OUTPUT_FEATURES-1:0]            weightAddr,
  output logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0]   outputData,
  output logic [LOG_BATCH_SIZE-1:0]                 outputAddr,
  output logic                                      outputWrEn
);

  localparam int FULL_W = INPUT_WIDTH + WEIGHT_WIDTH + LOG_INPUT_FEATURES;
`ifdef MATRIX_MULT_SATURATE_EN
  // Saturation needs the exact sum, with headroom so the compare never wraps.
  localparam int ACC_W  = FULL_W + OUTPUT_WIDTH;
`else
  // Wrapping only needs the low OUTPUT_WIDTH bits; modular arithmetic at this
  // width yields exactly those bits (and sign-extends when wider than FULL_W).
  localparam int ACC_W  = OUTPUT_WIDTH;
`endif

  localparam logic [LOG_BATCH_SIZE-1:0]      M_LAST = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
  localparam logic [LOG_OUTPUT_FEATURES-1:0] O_LAST = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                           state;
  state_t                           state_nxt;
  logic [LOG_BATCH_SIZE-1:0]        m_nxt;
  logic [LOG_OUTPUT_FEATURES-1:0]   o_nxt;

  // Address pair issued last cycle; its read data is on the ports now.
  logic                             rd_vld;
  logic [LOG_BATCH_SIZE-1:0]        rd_m;
  logic [LOG_OUTPUT_FEATURES-1:0]   rd_o;

  logic signed [INPUT_WIDTH-1:0]    lane_a;
  logic signed [WEIGHT_WIDTH-1:0]   lane_b;
  logic signed [ACC_W-1:0]          acc;
  logic [OUTPUT_WIDTH-1:0]          res;

  logic [OUTPUT_WIDTH-1:0]          slots [OUTPUT_FEATURES];
  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] row_full;

  // --------------------------------------------------------------------------
  // Sequencer: next state and next address pair
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    m_nxt     = inputAddr;
    o_nxt     = weightAddr;
    case (state)
      S_IDLE: begin
        m_nxt = '0;
        o_nxt = '0;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (weightAddr == O_LAST) begin
          o_nxt = '0;
          if (inputAddr == M_LAST) begin
            m_nxt     = '0;
            state_nxt = S_DRAIN;
          end else begin
            m_nxt = inputAddr + 1'b1;
          end
        end else begin
          o_nxt = weightAddr + 1'b1;
        end
      end
      S_DRAIN: begin
        m_nxt     = '0;
        o_nxt     = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        m_nxt     = '0;
        o_nxt     = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Dot product over the N lanes currently on the read-data ports
  // --------------------------------------------------------------------------
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    acc    = '0;
    for (int n = 0; n < INPUT_FEATURES; n++) begin
      lane_a = inputData[n*INPUT_WIDTH +: INPUT_WIDTH];
      lane_b = weightData[n*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      acc    = acc + ACC_W'(lane_a) * ACC_W'(lane_b);
    end
  end

`ifdef MATRIX_MULT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  always_comb begin
    res = acc[OUTPUT_WIDTH-1:0];
    if (acc > SAT_MAX)      res = SAT_MAX[OUTPUT_WIDTH-1:0];
    else if (acc < SAT_MIN) res = SAT_MIN[OUTPUT_WIDTH-1:0];
  end
`else
  assign res = acc;
`endif

  // The row written out includes the result being captured this cycle, so the
  // last lane bypasses its slot register.
  generate
    for (genvar o = 0; o < OUTPUT_FEATURES; o++) begin : g_row
      if (o == OUTPUT_FEATURES - 1) begin : g_last
        assign row_full[o*OUTPUT_WIDTH +: OUTPUT_WIDTH] = res;
      end else begin : g_slot
        assign row_full[o*OUTPUT_WIDTH +: OUTPUT_WIDTH] = slots[o];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State, address, read-tag, row-slot and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      inputAddr  <= '0;
      weightAddr <= '0;
      rd_vld     <= 1'b0;
      rd_m       <= '0;
      rd_o       <= '0;
      outputData <= '0;
      outputAddr <= '0;
      outputWrEn <= 1'b0;
      for (int i = 0; i < OUTPUT_FEATURES; i++) slots[i] <= '0;
    end else begin
      state      <= state_nxt;
      inputAddr  <= m_nxt;
      weightAddr <= o_nxt;
      rd_vld     <= (state == S_RUN);
      rd_m       <= inputAddr;
      rd_o       <= weightAddr;
      outputWrEn <= 1'b0;
      if (rd_vld) begin
        slots[rd_o] <= res;
        if (rd_o == O_LAST) begin
          outputData <= row_full;
          outputAddr <= rd_m;
          outputWrEn <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_mult
//  Purpose  : Self-checking bench for matrix_mult. Two instances share the
//             memories: the default configuration (OUTPUT_WIDTH=16) and a
//             narrow one (OUTPUT_WIDTH=8) that exercises wrap/saturation.
//             Expected rows come from a plain-integer matrix product.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_mult;

  localparam int M   = 8;
  localparam int N   = 4;
  localparam int O   = 8;
  localparam int IW  = 4;
  localparam int WW  = 8;
  localparam int OW  = 16;
  localparam int OW8 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [N*IW-1:0] inputData = '0;
  logic [N*WW-1:0] weightData = '0;

  logic [2:0]      inputAddr, outputAddr, inputAddr8, outputAddr8;
  logic [2:0]      weightAddr, weightAddr8;
  logic [O*OW-1:0] outputData;
  logic [O*OW8-1:0] outputData8;
  logic            outputWrEn, outputWrEn8;

  logic [N*IW-1:0] in_mem [M];
  logic [N*WW-1:0] w_mem  [O];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_mult dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .inputData(inputData), .weightData(weightData),
    .inputAddr(inputAddr), .weightAddr(weightAddr),
    .outputData(outputData), .outputAddr(outputAddr), .outputWrEn(outputWrEn)
  );

  matrix_mult #(.OUTPUT_WIDTH(OW8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .inputData(inputData), .weightData(weightData),
    .inputAddr(inputAddr8), .weightAddr(weightAddr8),
    .outputData(outputData8), .outputAddr(outputAddr8), .outputWrEn(outputWrEn8)
  );

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clk) begin
    inputData  <= in_mem[inputAddr];
    weightData <= w_mem[weightAddr];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reduce an exact dot product to ow bits.
  function automatic longint reduce(input longint full, input int ow);
    longint lo, hi, v;
    lo = -(longint'(1) <<< (ow - 1));
    hi = (longint'(1) <<< (ow - 1)) - 1;
    v  = full;
`ifdef MATRIX_MULT_SATURATE_EN
    if (v > hi) v = hi;
    if (v < lo) v = lo;
`endif
    return v & ((longint'(1) << ow) - 1);
  endfunction

  function automatic logic [127:0] exp_row(input int m, input int ow);
    logic [127:0] row;
    logic [N*IW-1:0] irow;
    logic [N*WW-1:0] wrow;
    longint full;
    int a, b;
    row  = '0;
    irow = in_mem[m];
    for (int o = 0; o < O; o++) begin
      wrow = w_mem[o];
      full = 0;
      for (int n = 0; n < N; n++) begin
        a = $signed(irow[n*IW +: IW]);
        b = $signed(wrow[n*WW +: WW]);
        full += longint'(a * b);
      end
      row |= 128'(reduce(full, ow)) << (o * ow);
    end
    return row;
  endfunction

  task automatic fill_random();
    logic [31:0] r;
    for (int m = 0; m < M; m++) begin r = $urandom; in_mem[m] = r[N*IW-1:0]; end
    for (int o = 0; o < O; o++) begin r = $urandom; w_mem[o]  = r[N*WW-1:0]; end
  endtask

  // Precondition: #1 after a rising edge. If !started, raise start and let the
  // next edge sample it. Checks every cycle 0..M*O+1 of one run.
  task automatic run_check(input bit started, input bit keep);
    int strobes;
    int expw;
    strobes = 0;
    if (!started) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    if (!keep) start = 1'b0;
    for (int c = 0; c <= M*O + 1; c++) begin
      if (c < M*O) begin
        chk("in_addr", 128'(inputAddr), 128'(c / O));
        chk("w_addr",  128'(weightAddr), 128'(c % O));
      end else if (c == M*O + 1) begin
        chk("idle_in_addr", 128'(inputAddr), 128'd0);
        chk("idle_w_addr",  128'(weightAddr), 128'd0);
      end
      expw = (c >= O + 1 && ((c - 1) % O) == 0) ? 1 : 0;
      chk("wr_en",  128'(outputWrEn),  128'(expw));
      chk("wr_en8", 128'(outputWrEn8), 128'(expw));
      if (outputWrEn) strobes++;
      if (expw == 1) begin
        chk("out_addr",  128'(outputAddr),  128'((c - 1) / O - 1));
        chk("out_data",  128'(outputData),  exp_row((c - 1) / O - 1, OW));
        chk("out_addr8", 128'(outputAddr8), 128'((c - 1) / O - 1));
        chk("out_data8", 128'(outputData8), exp_row((c - 1) / O - 1, OW8));
      end
      @(posedge clk); #1;
    end
    chk("strobe_count", 128'(strobes), 128'(M));
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk("idle_wr_en", 128'(outputWrEn), 128'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int m = 0; m < M; m++) in_mem[m] = '0;
    for (int o = 0; o < O; o++) w_mem[o]  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_addr",  128'(inputAddr),  128'd0);
    chk("rst_w_addr",   128'(weightAddr), 128'd0);
    chk("rst_out_data", 128'(outputData), 128'd0);
    chk("rst_out_addr", 128'(outputAddr), 128'd0);
    chk("rst_wr_en",    128'(outputWrEn), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_check(4);
    chk("idle_out_data", 128'(outputData), 128'd0);

    // Basic: IN all 1, W column o all = o
    for (int m = 0; m < M; m++) in_mem[m] = {N{4'h1}};
    for (int o = 0; o < O; o++) w_mem[o]  = {N{8'(o)}};
    run_check(1'b0, 1'b0);
    chk("basic_hold_data", 128'(outputData), 128'h001C_0018_0014_0010_000C_0008_0004_0000);
    chk("basic_hold_addr", 128'(outputAddr), 128'd7);

    // Signed extremes: (-8)*(-128)*4 = 4096
    for (int m = 0; m < M; m++) in_mem[m] = {N{4'h8}};
    for (int o = 0; o < O; o++) w_mem[o]  = {N{8'h80}};
    run_check(1'b0, 1'b0);
    chk("signed_data", 128'(outputData), {O{16'h1000}});
`ifdef MATRIX_MULT_SATURATE_EN
    chk("signed_data8", 128'(outputData8), 128'({O{8'h7F}}));
`else
    chk("signed_data8", 128'(outputData8), 128'({O{8'h00}}));
`endif

    // Random runs
    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_check(1'b0, 1'b0);
      idle_check(2);
    end

    // Asynchronous reset in the middle of cycle 20
    fill_random();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en",    128'(outputWrEn), 128'd0);
    chk("mid_rst_in_addr",  128'(inputAddr),  128'd0);
    chk("mid_rst_w_addr",   128'(weightAddr), 128'd0);
    chk("mid_rst_out_data", 128'(outputData), 128'd0);
    chk("mid_rst_out_addr", 128'(outputAddr), 128'd0);
    @(posedge clk); #1;
    idle_check(2);
    rst_n = 1'b1;
    idle_check(12);
    fill_random();
    run_check(1'b0, 1'b0);

    // Back-to-back runs with start held high
    fill_random();
    run_check(1'b0, 1'b1);
    run_check(1'b1, 1'b0);
    idle_check(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
